pipe_ctrl: RTL

Parametrised pipeline hazard and control unit for the RV32I pipeline, replacing the single-hold-flag control unit. Drives per-stage stall and flush vectors for all pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB). Arbitrates among:
- memory busy freeze
- multi-cycle EX hold, with timeout watchdog
- branch/jump redirect, with deferral when it cannot issue
- load-use bubble insertion

---
 rtl/pipe_ctrl.sv | 101 ++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: RV32I hazard/control unit (mem freeze, EX hold watchdog, jump deferral, load-use via PIPE_CTRL_LOAD_USE_EN)
module pipe_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int REG_AW   = 5,
  parameter int NSTAGE   = 5,
  parameter int HOLD_MAX = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_busy_i,
  input  logic              ex_hold_req_i,
  input  logic              jump_en_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              ex_mem_re_i,
  input  logic [REG_AW-1:0] ex_rd_addr_i,
  input  logic [REG_AW-1:0] id_rs1_addr_i,
  input  logic [REG_AW-1:0] id_rs2_addr_i,
  input  logic              id_rs1_used_i,
  input  logic              id_rs2_used_i,
  output logic [NSTAGE-1:0] stall_o,
  output logic [NSTAGE-1:0] flush_o,
  output logic              pc_jump_en_o,
  output logic [ADDR_W-1:0] pc_jump_addr_o,
  output logic              hold_timeout_o
);
  localparam int CW = $clog2(HOLD_MAX) + 1;
  typedef enum logic [1:0] {RUN, HOLD, ABORT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic pend_en_q, pend_en_d, timeout_q, timeout_d, load_use, jen;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d, jaddr;
  logic [NSTAGE-1:0] stall, flush;
`ifdef PIPE_CTRL_LOAD_USE_EN
  assign load_use = ex_mem_re_i && (ex_rd_addr_i != '0) &&
                    ((id_rs1_used_i && id_rs1_addr_i == ex_rd_addr_i) ||
                     (id_rs2_used_i && id_rs2_addr_i == ex_rd_addr_i));
`else
  logic unused_lu;
  assign unused_lu = ^{ex_mem_re_i, ex_rd_addr_i, id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i};
  assign load_use = 1'b0;
`endif
  always_comb begin
    stall = '0;
    flush = '0;
    jen = 1'b0;
    jaddr = '0;
    state_d = state_q;
    cnt_d = cnt_q;
    pend_en_d = pend_en_q;
    pend_addr_d = pend_addr_q;
    timeout_d = timeout_q;
    if (mem_busy_i) begin
      stall = '1;
      pend_en_d = pend_en_q | jump_en_i;
      pend_addr_d = jump_en_i ? jump_addr_i : pend_addr_q;
    end else if (state_q == ABORT) begin
      // a jump arriving while the watchdog drains is deferred rather than lost
      state_d = ex_hold_req_i ? ABORT : RUN;
      pend_en_d = pend_en_q | jump_en_i;
      pend_addr_d = jump_en_i ? jump_addr_i : pend_addr_q;
    end else if (ex_hold_req_i) begin
      stall[2:0] = 3'b111;
      flush[3] = 1'b1;
      pend_en_d = pend_en_q | jump_en_i;
      pend_addr_d = jump_en_i ? jump_addr_i : pend_addr_q;
      state_d = (cnt_q == CW'(HOLD_MAX - 1)) ? ABORT : HOLD;
      cnt_d = (cnt_q == CW'(HOLD_MAX - 1)) ? '0 : cnt_q + 1'b1;
      timeout_d = timeout_q | (cnt_q == CW'(HOLD_MAX - 1));
    end else begin
      state_d = RUN;
      cnt_d = '0;
      jen = jump_en_i | pend_en_q;
      jaddr = jump_en_i ? jump_addr_i : pend_en_q ? pend_addr_q : '0;
      flush[2:1] = jen ? 2'b11 : 2'b00;
      pend_en_d = 1'b0;
      stall[1:0] = (!jen && load_use) ? 2'b11 : 2'b00;
      flush[2] = jen | load_use;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q <= '0;
      pend_en_q <= 1'b0;
      pend_addr_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pend_en_q <= pend_en_d;
      pend_addr_q <= pend_addr_d;
      timeout_q <= timeout_d;
    end
  end
  // outputs are combinational, so reset must mask them without waiting for a clock
  assign stall_o = rst ? '0 : stall;
  assign flush_o = rst ? '0 : flush;
  assign pc_jump_en_o = rst ? 1'b0 : jen;
  assign pc_jump_addr_o = rst ? '0 : jaddr;
  assign hold_timeout_o = timeout_q;
endmodule
